// File: rtl/decode_hazard_stage.sv
// decode_hazard_stage
//
// Decode slot sitting between fetch and execute. Holds one instruction behind
// a valid/ready handshake, reads its operands from the external register file,
// forwards results from the EX and MEM producers, stalls on hazards, resolves
// branches and jumps (the delay slot is never squashed) and counts stall cycles.
//
// Build option:
//   DECODE_FWD_EN defined   : EX > MEM > regfile forwarding; only load-use stalls.
//   DECODE_FWD_EN undefined : operands straight from the regfile; any match with
//                             an enabled EX or MEM producer stalls.
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   in_valid / in_ready              upstream handshake
//   bundle_in, instr_in, pc_seq_in   incoming control bundle, instruction, sequential PC
//   out_valid / out_ready            downstream handshake
//   bundle_out                       control bundle bits [13:0] of the held instruction
//   operand_a_out, operand_b_out     ALU operands (after a-sel / b-sel)
//   reg_read2_out                    forwarded rt value (store data)
//   reg_write_dest_out               destination register of the held instruction
//   pc_seq_out                       held sequential PC
//   rs_addr_out, rt_addr_out         register file read addresses
//   rs_data_in, rt_data_in           register file read data (same cycle)
//   ex_wr_en_in, ex_is_load_in,
//   ex_dest_in, ex_data_in           EX-stage producer
//   mem_wr_en_in, mem_dest_in,
//   mem_data_in                      MEM-stage producer
//   flush_in                         kill the held instruction
//   redirect_out, redirect_addr_out  control-transfer request (fire cycle only)
//   stall_count_out                  saturating stall-cycle counter

module decode_hazard_stage #(
    parameter int unsigned       W         = 32,
    parameter int unsigned       RA        = 5,
    parameter int unsigned       BUNDLE_W  = 26,
    parameter logic [W-1:0]      RESET_PC  = 'h003ffffc,
    parameter logic [31:0]       NOP_INSTR = 32'h34000000
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BUNDLE_W-1:0] bundle_in,
    input  logic [31:0]         instr_in,
    input  logic [W-1:0]        pc_seq_in,

    output logic                out_valid,
    input  logic                out_ready,
    output logic [13:0]         bundle_out,
    output logic [W-1:0]        operand_a_out,
    output logic [W-1:0]        operand_b_out,
    output logic [W-1:0]        reg_read2_out,
    output logic [RA-1:0]       reg_write_dest_out,
    output logic [W-1:0]        pc_seq_out,

    output logic [RA-1:0]       rs_addr_out,
    output logic [RA-1:0]       rt_addr_out,
    input  logic [W-1:0]        rs_data_in,
    input  logic [W-1:0]        rt_data_in,

    input  logic                ex_wr_en_in,
    input  logic                ex_is_load_in,
    input  logic [RA-1:0]       ex_dest_in,
    input  logic [W-1:0]        ex_data_in,

    input  logic                mem_wr_en_in,
    input  logic [RA-1:0]       mem_dest_in,
    input  logic [W-1:0]        mem_data_in,

    input  logic                flush_in,

    output logic                redirect_out,
    output logic [W-1:0]        redirect_addr_out,
    output logic [15:0]         stall_count_out
);

    // Control bundle bit positions
    localparam int unsigned A_SEL_BIT     = 16;
    localparam int unsigned B_SEL_BIT     = 17;
    localparam int unsigned BRANCH_BIT    = 21;
    localparam int unsigned JUMP_BIT      = 22;
    localparam int unsigned JUMP_IMM_BIT  = 23;
    localparam int unsigned FUNC0_BIT     = 8;

    localparam logic [BUNDLE_W-1:0] RESET_BUNDLE = BUNDLE_W'(26'h00e2531);
    localparam logic [15:0]         COUNT_MAX    = 16'hFFFF;

    // Held slot
    logic                slot_valid;
    logic [BUNDLE_W-1:0] slot_bundle;
    logic [31:0]         slot_instr;
    logic [W-1:0]        slot_pc;
    logic [15:0]         stall_count;

    // Instruction fields
    logic [4:0]    rs_field;
    logic [4:0]    rt_field;
    logic [4:0]    rd_field;
    logic [4:0]    shamt;
    logic [15:0]   imm16;
    logic [25:0]   imm26;
    logic [RA-1:0] rs_addr;
    logic [RA-1:0] rt_addr;
    logic [W-1:0]  imm_sext;

    assign rs_field = slot_instr[25:21];
    assign rt_field = slot_instr[20:16];
    assign rd_field = slot_instr[15:11];
    assign shamt    = slot_instr[10:6];
    assign imm16    = slot_instr[15:0];
    assign imm26    = slot_instr[25:0];
    assign rs_addr  = RA'(rs_field);
    assign rt_addr  = RA'(rt_field);
    assign imm_sext = W'($signed(imm16));

    // Which register sources the held instruction actually reads
    logic rs_used;
    logic rt_used;

    assign rs_used = !slot_bundle[A_SEL_BIT] | slot_bundle[BRANCH_BIT]
                   | (slot_bundle[JUMP_BIT] & !slot_bundle[JUMP_IMM_BIT]);
    assign rt_used = !slot_bundle[B_SEL_BIT] | slot_bundle[BRANCH_BIT];

    // Producer matches; register 0 is hard zero and never matches
    logic ex_hit_rs;
    logic ex_hit_rt;
    logic mem_hit_rs;
    logic mem_hit_rt;

    assign ex_hit_rs  = ex_wr_en_in  && (ex_dest_in  == rs_addr) && (rs_addr != '0);
    assign ex_hit_rt  = ex_wr_en_in  && (ex_dest_in  == rt_addr) && (rt_addr != '0);
    assign mem_hit_rs = mem_wr_en_in && (mem_dest_in == rs_addr) && (rs_addr != '0);
    assign mem_hit_rt = mem_wr_en_in && (mem_dest_in == rt_addr) && (rt_addr != '0);

    // Source values and per-source hazard
    logic [W-1:0] rs_val;
    logic [W-1:0] rt_val;
    logic         rs_block;
    logic         rt_block;

    always_comb begin
        rs_val   = rs_data_in;
        rt_val   = rt_data_in;
        rs_block = 1'b0;
        rt_block = 1'b0;
`ifdef DECODE_FWD_EN
        if (ex_hit_rs) begin
            rs_val = ex_data_in;
        end else if (mem_hit_rs) begin
            rs_val = mem_data_in;
        end
        if (ex_hit_rt) begin
            rt_val = ex_data_in;
        end else if (mem_hit_rt) begin
            rt_val = mem_data_in;
        end
        // A load in EX has no data yet: only that case blocks
        rs_block = ex_hit_rs & ex_is_load_in;
        rt_block = ex_hit_rt & ex_is_load_in;
`else
        rs_block = ex_hit_rs | mem_hit_rs;
        rt_block = ex_hit_rt | mem_hit_rt;
`endif
    end

    // Handshake
    logic stall;
    logic fire;
    logic capture;

    assign stall = (rs_used & rs_block) | (rt_used & rt_block);

    // A flushed slot must not be seen as valid by downstream in the kill cycle
    assign out_valid = slot_valid & !stall & !flush_in;
    assign fire      = out_valid & out_ready;
    // Flush frees the slot, so a same-cycle capture replaces the killed instruction
    assign in_ready  = !slot_valid | fire | flush_in;
    assign capture   = in_valid & in_ready;

    // Branch / jump resolution
    logic         branch_taken;
    logic [W-1:0] branch_target;
    logic [W-1:0] jump_target;

    assign branch_taken  = slot_bundle[BRANCH_BIT]
                         & ((rs_val == rt_val) ^ slot_bundle[FUNC0_BIT]);
    assign branch_target = slot_pc + {imm_sext[W-3:0], 2'b00};
    assign jump_target   = slot_bundle[JUMP_IMM_BIT] ? {slot_pc[W-1:28], imm26, 2'b00}
                                                     : rs_val;

    assign redirect_out      = fire & (slot_bundle[JUMP_BIT] | branch_taken);
    assign redirect_addr_out = slot_bundle[JUMP_BIT] ? jump_target : branch_target;

    // Destination: jal links $31, immediate forms write rt, register forms write rd
    always_comb begin
        reg_write_dest_out = RA'(rd_field);
        if (slot_bundle[JUMP_BIT] && slot_bundle[JUMP_IMM_BIT]) begin
            reg_write_dest_out = '1;
        end else if (slot_bundle[B_SEL_BIT]) begin
            reg_write_dest_out = RA'(rt_field);
        end
    end

    // Operands: a-sel picks the shift amount, b-sel the sign-extended immediate
    assign operand_a_out = slot_bundle[A_SEL_BIT] ? W'(shamt) : rs_val;
    assign operand_b_out = slot_bundle[B_SEL_BIT] ? imm_sext  : rt_val;
    assign reg_read2_out = rt_val;

    assign bundle_out      = slot_bundle[13:0];
    assign pc_seq_out      = slot_pc;
    assign rs_addr_out     = rs_addr;
    assign rt_addr_out     = rt_addr;
    assign stall_count_out = stall_count;

    // Slot register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_valid  <= 1'b0;
            slot_bundle <= RESET_BUNDLE;
            slot_instr  <= NOP_INSTR;
            slot_pc     <= RESET_PC;
        end else if (capture) begin
            slot_valid  <= 1'b1;
            slot_bundle <= bundle_in;
            slot_instr  <= instr_in;
            slot_pc     <= pc_seq_in;
        end else if (fire || flush_in) begin
            slot_valid  <= 1'b0;
            slot_instr  <= NOP_INSTR;
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= 16'd0;
        end else if (slot_valid && stall && (stall_count != COUNT_MAX)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

    // Bundle/opcode bits not consumed by this stage
    logic unused_bits;
`ifdef DECODE_FWD_EN
    assign unused_bits = ^{slot_instr[31:26], slot_bundle[BUNDLE_W-1:24],
                           slot_bundle[20:18], slot_bundle[15:14]};
`else
    assign unused_bits = ^{slot_instr[31:26], slot_bundle[BUNDLE_W-1:24],
                           slot_bundle[20:18], slot_bundle[15:14],
                           ex_is_load_in, ex_data_in, mem_data_in};
`endif

endmodule

// File: doc/decode_hazard_stage.md
# decode_hazard_stage

Parametrised successor to the current decode stage of the pipelined MIPS core. Holds one instruction in a valid/ready pipeline slot and reads operands from the external regfile. Forwards results from EX and MEM, detects RAW and load-use hazards, and stalls. Resolves branches and jumps (delay-slot semantics kept) and counts stall cycles. Sits between fetch and execute, in place of the fixed-function decode block.

## Interface
- W, 32: datapath width.
- RA, 5: register address width; register 0 is hard zero.
- BUNDLE_W, 26: control bundle width; bit layout unchanged: [13:8] alu func, [16] a-sel, [17] b-sel, [21] is_branch, [22] jump, [23] jump imm/reg.
- RESET_PC, 32'h003ffffc: reset value of the held PC.
- NOP_INSTR, 32'h34000000: reset/bubble value of the held instruction.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- in_valid / in_ready  in / out  1  upstream handshake.
- bundle_in, instr_in, pc_seq_in  in  BUNDLE_W, 32, W  incoming instruction.
- out_valid / out_ready  out / in  1  downstream handshake.
- bundle_out  out  14  bundle[13:0] of the held instruction.
- operand_a_out, operand_b_out, reg_read2_out  out  W  forwarded operands.
- reg_write_dest_out  out  RA  destination, chosen as in the current decode.
- pc_seq_out  out  W  held PC.
- rs_addr_out, rt_addr_out  out  RA  regfile read addresses.
- rs_data_in, rt_data_in  in  W  regfile read data, same cycle.
- ex_wr_en_in, ex_is_load_in, ex_dest_in, ex_data_in  in  1, 1, RA, W  EX-stage producer.
- mem_wr_en_in, mem_dest_in, mem_data_in  in  1, RA, W  MEM-stage producer.
- flush_in  in  1  kill the held instruction.
- redirect_out, redirect_addr_out  out  1, W  control-transfer request.
- stall_count_out  out  16  saturating stall-cycle counter.

## Operation
- Slot state: valid, bundle, instr, pc.
- fire = out_valid & out_ready.
- in_ready = !valid | fire.
- Capture on in_valid & in_ready. If nothing is captured but fire occurs, valid clears and instr becomes NOP_INSTR.
- Source use:
  - rs_used = !bundle[16] | bundle[21] | (bundle[22] & !bundle[23]).
  - rt_used = !bundle[17] | bundle[21].
- Register 0 never matches a producer.
- Forwarding priority: EX over MEM over regfile. A producer matches when its wr_en is set and its dest equals the source address.
- Load-use hazard: a used source matches EX with ex_is_load_in=1. Set stall=1 while the hazard persists.
- out_valid = valid & !stall.
- stall_count_out increments each cycle valid & stall, and saturates at 16'hFFFF.
- Branch target: pc_seq + (sext(imm16)<<2). Taken when operands are equal and alu func[0]=0, or unequal and func[0]=1. Compare uses forwarded values.
- Jump target: bundle[23]=1 gives {pc_seq[W-1:28], imm26, 2'b00}; bundle[23]=0 gives the forwarded rs.
- redirect_out=1 only in a fire cycle of a taken branch or jump. The next sequential instruction, the delay slot, is never squashed.
- flush_in: valid clears at the next edge, and the held slot does not fire in that cycle. A same-cycle capture still happens, so the new instruction replaces the killed one.

## Timing
- Reset (async) values:
  - valid=0, out_valid=0, redirect_out=0, stall_count_out=0.
  - instr=NOP_INSTR, pc=RESET_PC.
  - Held bundle = 26'h00e2531, so bundle_out=14'h2531.
- Latency: one cycle from capture to out_valid, assuming no hazard.
- Throughput: one per cycle when out_ready stays high.
- Operands, hazard detection and redirect are combinational from the held slot and producer inputs, evaluated the same cycle.
- A stall holds in_ready low unless valid=0. Upstream must hold its data while in_valid & !in_ready.
- Reset asserted mid-stall clears the slot and counter immediately, with no residual redirect.

## Configuration
- DECODE_FWD_EN defined: forwarding as above, and only load-use stalls.
- DECODE_FWD_EN undefined:
  - No forwarding muxes; operands always come from regfile data.
  - Any match with an enabled EX or MEM producer stalls.
  - stall_count_out counts these stalls as well.

## Test plan
- Reset, then release: out_valid=0, bundle_out=14'h2531, pc_seq_out=32'h003ffffc, stall_count_out=0.
- `addu $3,$1,$2` issued while EX writes $1 with 32'h11 and MEM writes $2 with 32'h22: with forwarding, operand_a_out=32'h11 and operand_b_out=32'h22 in a single cycle. Without forwarding, stall until both producers retire.
- `lw` in EX to $4, then `addu $5,$4,$4` held: out_valid=0 for one cycle and stall_count_out=1. The cycle after EX advances, out_valid=1 with mem_data_in forwarded.
- beq at pc 32'h100 with imm 16'hFFFF and equal operands: on fire, redirect_out=1 and redirect_addr_out=32'h100. The next instruction, the delay slot, still captures.
- EX writing $0 with 32'hDEAD while a consumer reads $0: no stall, and the operand equals rs_data_in.
- flush_in raised while stalled, with in_valid=1 and a new instruction: the old one never fires, the new one is captured, and out_valid rises the next cycle.
